// File: rtl/mma_tiler_pkg.sv
// Shared defaults, guard-width helper and tile typedefs for the K-tiled MMA engine.
package mma_tiler_pkg;

  localparam int M_DEF    = 8;
  localparam int N_DEF    = 4;
  localparam int KT_DEF   = 16;
  localparam int P_DEF    = 8;
  localparam int ACCW_DEF = 32;
  localparam int TW_DEF   = 8;

  // Extra headroom bits so one beat's worth of products plus the base never wraps
  // inside the extended sum; overflow of the ACCW result is judged on these bits.
  function automatic int guard_width(input int kt);
    return $clog2(kt) + 2;
  endfunction

  typedef logic [M_DEF-1:0][KT_DEF-1:0][P_DEF-1:0]   a_tile_t;
  typedef logic [KT_DEF-1:0][N_DEF-1:0][P_DEF-1:0]   b_tile_t;
  typedef logic [M_DEF-1:0][N_DEF-1:0][ACCW_DEF-1:0] acc_mat_t;

  // Group tracking: IDLE means the next beat must open a group.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } grp_state_e;

endpackage

// File: rtl/mma_dot_tile.sv
// Combinational M x N array of length-KT dot products added onto an extended base.
module mma_dot_tile
  import mma_tiler_pkg::*;
#(
  parameter int  M    = M_DEF,
  parameter int  N    = N_DEF,
  parameter int  KT   = KT_DEF,
  parameter int  P    = P_DEF,
  parameter int  ACCW = ACCW_DEF,
  localparam int EW   = ACCW + guard_width(KT)
) (
  input  logic                             signed_i,
  input  logic [M-1:0][KT-1:0][P-1:0]      a_i,
  input  logic [KT-1:0][N-1:0][P-1:0]      b_i,
  input  logic [M-1:0][N-1:0][ACCW-1:0]    base_i,
  output logic [M-1:0][N-1:0][EW-1:0]      sum_o
);

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [EW-1:0]    sum_d;
      logic signed [P:0]       a_x;
      logic signed [P:0]       b_x;
      logic signed [2*P+1:0]   prod;

      // Operands get one extra bit (sign or zero) so a single signed multiplier covers both modes.
      always_comb begin
        sum_d = EW'($signed(base_i[gi][gj]));
        a_x   = '0;
        b_x   = '0;
        prod  = '0;
        for (int k = 0; k < KT; k++) begin
          a_x   = signed_i ? {a_i[gi][k][P-1], a_i[gi][k]} : {1'b0, a_i[gi][k]};
          b_x   = signed_i ? {b_i[k][gj][P-1], b_i[k][gj]} : {1'b0, b_i[k][gj]};
          prod  = a_x * b_x;
          sum_d = sum_d + EW'(prod);
        end
      end

      assign sum_o[gi][gj] = sum_d;
    end
  end

endmodule

// File: rtl/mma_k_tiler.sv
// K-tiled MMA engine: accumulates A*B tiles onto C per group, double-buffers the result.
module mma_k_tiler
  import mma_tiler_pkg::*;
#(
  parameter int M    = M_DEF,
  parameter int N    = N_DEF,
  parameter int KT   = KT_DEF,
  parameter int P    = P_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int TW   = TW_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [M-1:0][KT-1:0][P-1:0]   a_i,
  input  logic [KT-1:0][N-1:0][P-1:0]   b_i,
  input  logic [M-1:0][N-1:0][ACCW-1:0] c_i,
  input  logic                          first_i,
  input  logic                          last_i,
  input  logic                          signed_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [M-1:0][N-1:0][ACCW-1:0] d_o,
  output logic [TW-1:0]                 tiles_o,
  output logic                          ovf_o,
  output logic                          err_o
);

  localparam int             G        = guard_width(KT);
  localparam int             EW       = ACCW + G;
  localparam logic [TW-1:0]  TCNT_MAX = '1;

  grp_state_e                    state_q, state_d;
  logic [M-1:0][N-1:0][ACCW-1:0] acc_q, acc_d;
  logic [M-1:0][N-1:0][ACCW-1:0] d_q, d_d;
  logic [TW-1:0]                 tcnt_q, tcnt_d;
  logic [TW-1:0]                 tiles_q, tiles_d;
  logic                          ovf_grp_q, ovf_grp_d;
  logic                          ovf_out_q, ovf_out_d;
  logic                          out_valid_q, out_valid_d;
  logic                          err_q, err_d;

  logic [M-1:0][N-1:0][ACCW-1:0] base;
  logic [M-1:0][N-1:0][EW-1:0]   sum_w;
  logic                          accept;
  logic                          start;
  logic                          any_ovf;
  logic [TW-1:0]                 tcnt_new;
  logic                          ovf_new;

  // Beats stall whenever the output slot is occupied and not being drained this cycle.
  assign in_ready_o = !rst_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  // A beat arriving outside a group is treated as a group start even without first_i.
  assign start      = first_i || (state_q == ST_IDLE);
  assign base       = start ? c_i : acc_q;

  mma_dot_tile #(
    .M    (M),
    .N    (N),
    .KT   (KT),
    .P    (P),
    .ACCW (ACCW)
  ) u_dot (
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .base_i   (base),
    .sum_o    (sum_w)
  );

  // A sum fits in signed ACCW only if its top G+1 bits are all equal.
  always_comb begin
    any_ovf = 1'b0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        if ((sum_w[m][n][EW-1:ACCW-1] != '0) && (sum_w[m][n][EW-1:ACCW-1] != '1)) begin
          any_ovf = 1'b1;
        end
      end
    end
  end

  // Next-state: group FSM, accumulator, tile count, sticky error and output slot.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tcnt_d      = tcnt_q;
    ovf_grp_d   = ovf_grp_q;
    d_d         = d_q;
    tiles_d     = tiles_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    tcnt_new    = start ? TW'(1) : ((tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + TW'(1));
    ovf_new     = (start ? 1'b0 : ovf_grp_q) | any_ovf;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) begin
          acc_d[m][n] = sum_w[m][n][ACCW-1:0];
        end
      end
      tcnt_d    = tcnt_new;
      ovf_grp_d = ovf_new;
      // first_i must be set exactly when no group is open.
      if (first_i == (state_q == ST_ACC)) begin
        err_d = 1'b1;
      end
      state_d = last_i ? ST_IDLE : ST_ACC;
      if (last_i) begin
        d_d         = acc_d;
        tiles_d     = tcnt_new;
        ovf_out_d   = ovf_new;
        out_valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      tcnt_q      <= '0;
      ovf_grp_q   <= 1'b0;
      d_q         <= '0;
      tiles_q     <= '0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tcnt_q      <= tcnt_d;
      ovf_grp_q   <= ovf_grp_d;
      d_q         <= d_d;
      tiles_q     <= tiles_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign d_o         = d_q;
  assign tiles_o     = tiles_q;
  assign ovf_o       = ovf_out_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mma_k_tiler.sv
// Bench for mma_k_tiler: directed beats, a cycle-level reference model, literal pins.
module tb_mma_k_tiler;
  import mma_tiler_pkg::*;

  localparam int M  = M_DEF;
  localparam int N  = N_DEF;
  localparam int KT = KT_DEF;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  a_tile_t     a_i = '0;
  b_tile_t     b_i = '0;
  acc_mat_t    c_i = '0;
  logic        first_i = 1'b0;
  logic        last_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  acc_mat_t    d_o;
  logic [7:0]  tiles_o;
  logic        ovf_o;
  logic        err_o;

  int vec = 0;
  int miscompares = 0;
  int valid_cycles = 0;

  // Reference model state (as observed after each rising edge)
  bit       m_init = 0;
  bit       m_in_group = 0;
  bit       m_err = 0;
  bit       m_valid = 0;
  bit       m_ovf = 0;
  bit       m_ovf_out = 0;
  int       m_tcnt = 0;
  int       m_tiles = 0;
  longint   m_acc [M][N];
  acc_mat_t m_d = '0;

  always #5 clk = ~clk;

  mma_k_tiler u_dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .c_i         (c_i),
    .first_i     (first_i),
    .last_i      (last_i),
    .signed_i    (signed_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .d_o         (d_o),
    .tiles_o     (tiles_o),
    .ovf_o       (ovf_o),
    .err_o       (err_o)
  );

  task automatic model_step();
    bit     do_acc, st, any_o;
    longint s;
    if (rst_i) begin
      m_init = 1; m_in_group = 0; m_err = 0; m_valid = 0; m_ovf = 0;
      m_ovf_out = 0; m_tcnt = 0; m_tiles = 0; m_d = '0;
      for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) m_acc[m][n] = 0;
      return;
    end
    do_acc = in_valid_i && (!m_valid || out_ready_i);
    if (!do_acc) begin
      if (m_valid && out_ready_i) m_valid = 0;
      return;
    end
    st = first_i || !m_in_group;
    if (first_i == m_in_group) m_err = 1;
    any_o = 0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        s = st ? longint'($signed(c_i[m][n])) : m_acc[m][n];
        for (int k = 0; k < KT; k++) begin
          if (signed_i) s += longint'($signed(a_i[m][k])) * longint'($signed(b_i[k][n]));
          else          s += longint'(a_i[m][k]) * longint'(b_i[k][n]);
        end
        if (s > 64'sd2147483647 || s < -64'sd2147483648) any_o = 1;
        m_acc[m][n] = longint'($signed(s[31:0]));
      end
    end
    m_tcnt = st ? 1 : ((m_tcnt >= 255) ? 255 : m_tcnt + 1);
    m_ovf  = (st ? 1'b0 : m_ovf) | any_o;
    m_in_group = !last_i;
    $display("beat t=%0t first=%0d last=%0d signed=%0d tcnt=%0d", $time, first_i, last_i, signed_i, m_tcnt);
    if (last_i) begin
      for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) m_d[m][n] = m_acc[m][n][31:0];
      m_tiles = m_tcnt; m_ovf_out = m_ovf; m_valid = 1;
    end else if (m_valid && out_ready_i) begin
      m_valid = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Cycle compare against the model, mid-cycle when inputs and outputs are settled
  initial forever begin
    @(negedge clk);
    if (out_valid_o) valid_cycles++;
    if (m_init) begin
      bit d_bad;
      vec++;
      if (in_ready_o !== (!rst_i && (!m_valid || out_ready_i))) begin
        miscompares++;
        $display("FAIL in_ready t=%0t got=%0b exp=%0b", $time, in_ready_o, !rst_i && (!m_valid || out_ready_i));
      end
      vec++;
      if (out_valid_o !== m_valid) begin
        miscompares++;
        $display("FAIL out_valid t=%0t got=%0b exp=%0b", $time, out_valid_o, m_valid);
      end
      vec++;
      if (err_o !== m_err) begin
        miscompares++;
        $display("FAIL err t=%0t got=%0b exp=%0b", $time, err_o, m_err);
      end
      vec++;
      if (tiles_o !== 8'(m_tiles)) begin
        miscompares++;
        $display("FAIL tiles t=%0t got=%0d exp=%0d", $time, tiles_o, m_tiles);
      end
      vec++;
      if (ovf_o !== m_ovf_out) begin
        miscompares++;
        $display("FAIL ovf t=%0t got=%0b exp=%0b", $time, ovf_o, m_ovf_out);
      end
      vec++;
      d_bad = 0;
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) begin
          if (!d_bad && d_o[m][n] !== m_d[m][n]) begin
            d_bad = 1;
            $display("FAIL d t=%0t [%0d][%0d] got=%0h exp=%0h", $time, m, n, d_o[m][n], m_d[m][n]);
          end
        end
      end
      if (d_bad) miscompares++;
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    vec++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
    end
  endtask

  task automatic beat(input int av, input int bv, input logic [31:0] cv,
                      input bit f, input bit l, input bit s, input bit pat, input bit ordy);
    @(posedge clk); #2;
    rst_i = 0; in_valid_i = 1; first_i = f; last_i = l; signed_i = s; out_ready_i = ordy;
    for (int m = 0; m < M; m++)
      for (int k = 0; k < KT; k++) a_i[m][k] = pat ? 8'(m*37 + k*11 + 200) : 8'(av);
    for (int k = 0; k < KT; k++)
      for (int n = 0; n < N; n++) b_i[k][n] = pat ? 8'(k*13 - n*29 + 5) : 8'(bv);
    for (int m = 0; m < M; m++)
      for (int n = 0; n < N; n++) c_i[m][n] = pat ? cv + 32'(m*100 + n) : cv;
  endtask

  task automatic idle(input bit ordy);
    @(posedge clk); #2;
    rst_i = 0; in_valid_i = 0; first_i = 0; last_i = 0; out_ready_i = ordy;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    rst_i = 1; in_valid_i = 0; out_ready_i = 1;
    for (int i = 1; i < cycles; i++) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int vc0;
    // Reset state
    do_reset(3);
    #1 chk("ready_in_reset", in_ready_o, 0);
    idle(1);
    #1 chk("ready_after_reset", in_ready_o, 1);
    chk("reset_valid", out_valid_o, 0);
    chk("reset_d", longint'(d_o[0][0]), 0);

    // Single-tile group: 5 + 16*1*2 = 37
    beat(1, 2, 32'd5, 1, 1, 1, 0, 1);
    idle(1);
    #1 chk("single_d", longint'(d_o[M-1][N-1]), 37);
    chk("single_tiles", tiles_o, 1);
    chk("single_valid", out_valid_o, 1);

    // Three-tile group: 3 * 16 = 48, one result cycle
    idle(1);
    vc0 = valid_cycles;
    beat(1, 1, 32'd0, 1, 0, 1, 0, 1);
    beat(1, 1, 32'd0, 0, 0, 1, 0, 1);
    beat(1, 1, 32'd0, 0, 1, 1, 0, 1);
    idle(1);
    #1 chk("three_d", longint'(d_o[3][2]), 48);
    chk("three_tiles", tiles_o, 3);
    idle(1);
    idle(1);
    chk("three_valid_once", valid_cycles - vc0, 1);

    // Signedness: (-1)(-1)*16 = 16 ; 255*255*16 = 1040400
    beat(8'hFF, 8'hFF, 32'd0, 1, 1, 1, 0, 1);
    beat(8'hFF, 8'hFF, 32'd0, 1, 1, 0, 0, 1);
    #1 chk("signed_d", longint'(d_o[0][1]), 16);
    idle(1);
    #1 chk("unsigned_d", longint'(d_o[0][1]), 1040400);

    // Overflow: 0x7FFFFFF0 + 16 wraps to 0x80000000
    beat(1, 1, 32'h7FFFFFF0, 1, 1, 1, 0, 1);
    idle(1);
    #1 chk("ovf_d", longint'(d_o[2][3]), 64'h80000000);
    chk("ovf_flag", ovf_o, 1);

    // Patterned two-tile group, mixed signedness, ovf cleared by new group
    beat(0, 0, 32'd1000, 1, 0, 1, 1, 1);
    beat(0, 0, 32'd0, 0, 1, 0, 1, 1);
    idle(1);
    #1 chk("pat_ovf_clear", ovf_o, 0);

    // Back-pressure: 1 + 16*2*3 = 97 held for 5 cycles
    beat(2, 3, 32'd1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      beat(1, 1, 32'd0, 1, 1, 1, 0, 0);
      #1 chk("bp_ready", in_ready_o, 0);
      chk("bp_hold_d", longint'(d_o[1][1]), 97);
    end
    beat(1, 1, 32'd0, 1, 1, 1, 0, 1);
    idle(1);
    #1 chk("bp_new_d", longint'(d_o[1][1]), 16);
    chk("bp_valid_kept", out_valid_o, 1);
    idle(1);

    // Missing first after reset: base is C: 7 + 16 = 23
    do_reset(2);
    beat(1, 1, 32'd7, 0, 1, 1, 0, 1);
    idle(1);
    #1 chk("nofirst_d", longint'(d_o[0][0]), 23);
    chk("nofirst_err", err_o, 1);

    // First mid-group: discarded partial, result 16
    do_reset(2);
    beat(3, 3, 32'd0, 1, 0, 1, 0, 1);
    beat(1, 1, 32'd0, 1, 1, 1, 0, 1);
    idle(1);
    #1 chk("midfirst_d", longint'(d_o[0][0]), 16);
    chk("midfirst_err", err_o, 1);
    chk("midfirst_tiles", tiles_o, 1);

    // Reset mid-group clears outputs and error
    beat(1, 1, 32'd0, 1, 0, 1, 0, 1);
    do_reset(1);
    idle(1);
    #1 chk("rst_valid", out_valid_o, 0);
    chk("rst_tiles", tiles_o, 0);
    chk("rst_err", err_o, 0);
    beat(1, 1, 32'd9, 0, 1, 1, 0, 1);
    idle(1);
    #1 chk("rst_nofirst_d", longint'(d_o[0][0]), 25);
    chk("rst_nofirst_err", err_o, 1);

    // Tile counter saturation over a 300-beat group
    do_reset(2);
    beat(0, 0, 32'd3, 1, 0, 1, 0, 1);
    for (int i = 0; i < 298; i++) beat(0, 0, 32'd0, 0, 0, 1, 0, 1);
    beat(1, 1, 32'd0, 0, 1, 1, 0, 1);
    idle(1);
    #1 chk("sat_tiles", tiles_o, 255);
    chk("sat_d", longint'(d_o[0][0]), 19);
    idle(1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

endmodule
